predicate_speculation_resolver: RTL
===================================

Name: predicate_speculation_resolver

Overview:
- Producer/checker side of the predicate predictor bank.
- Records each speculative predicate prediction consumed by the trigger stage in an in-order FIFO.
- Compares each recorded prediction against the datapath's actual predicate write and raises a mispredict/squash when they differ.
- Drives the bank's training inputs (datapath_write, datapath_di, observed_value) from resolved writes.

Parameters:
- DEPTH, 4: maximum outstanding speculations; power of two, >= 2.
- FLUSH_CYCLES, 2: cycles squash stays asserted after a mispredict; >= 1.
- TIA_NUM_PREDICATES and TIA_DI_WIDTH come from control.svh; they are not module parameters.

Ports:
- clock  in  1  clock; positive-edge triggered.
- reset  in  1  reset; asynchronous, active-low.
- enable  in  1  active high; when low, all state holds.
- spec_valid  in  1  trigger stage consumed a predicted predicate.
- spec_ready  out  1  a speculation can be accepted this cycle.
- spec_index  in  $clog2(TIA_NUM_PREDICATES)  predicate that was predicted.
- spec_value  in  1  predicted value.
- resolve_valid  in  1  datapath writes a predicate this cycle.
- resolve_di  in  TIA_DI_WIDTH  destination index; low $clog2(TIA_NUM_PREDICATES) bits select the predicate.
- resolve_value  in  1  actual written value.
- datapath_write  out  1  training write strobe to the predictor bank.
- datapath_di  out  TIA_DI_WIDTH  training destination.
- observed_value  out  1  training value.
- mispredict  out  1  one-cycle pulse on a detected mismatch.
- squash  out  1  pipeline flush request.
- outstanding  out  $clog2(DEPTH+1)  current FIFO occupancy.
- resolved_count  out  16  see Optional Feature.
- mispredict_count  out  16  see Optional Feature.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FIFO is emptied; state goes to RUN.
  - All outputs are 0, except spec_ready, which is 1 once reset is released.
- States: RUN, FLUSH. A flush counter runs only in FLUSH.
- spec_ready = enable & (state==RUN) & (outstanding<DEPTH).
- Push: when spec_valid & spec_ready, {spec_index, spec_value} is written at the tail.
- Resolve, evaluated only when enable & resolve_valid & state==RUN:
  - Training outputs are registered, latency 1 cycle: datapath_write=1, datapath_di=resolve_di, observed_value=resolve_value.
  - If FIFO is non-empty and the head index equals resolve_di's predicate bits, the head is popped (retire).
  - On retire with head value == resolve_value: no further action.
  - On retire with head value != resolve_value:
    - mispredict pulses 1 on the next cycle.
    - State goes to FLUSH and the whole FIFO is cleared.
  - If FIFO is empty or the index does not match the head: the write is non-speculative; training only, no pop, no compare.
- FLUSH:
  - squash=1 for exactly FLUSH_CYCLES cycles, starting the cycle after the mispredicting resolve.
  - spec_ready=0; resolve_valid is still forwarded for training but never compared.
  - Returns to RUN after the count expires.
- Simultaneous events:
  - Push and retire in the same cycle: both take effect and occupancy is unchanged. Push into a full FIFO is allowed only if a retire occurs that same cycle; spec_ready still reports 0 when full (conservative).
  - Push in the same cycle as a mispredict: the push is discarded, and occupancy is 0 on entering FLUSH.
- Pointers wrap modulo DEPTH. Occupancy uses a separate counter, so full and empty are unambiguous.
- enable=0:
  - No push, pop, or state/counter change.
  - datapath_write and mispredict are driven 0.
  - squash holds its value.
- Reset mid-FLUSH: returns to RUN with squash=0 immediately (asynchronously).

Optional Feature:
- Macro: PREDICATE_SPECULATION_STATS_EN.
- Defined:
  - resolved_count increments on every retire.
  - mispredict_count increments on every mispredict.
  - Both are 16-bit, saturate at 0xFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- Push (idx 2, val 1), then resolve di=2, val 1 -> next cycle datapath_write=1, datapath_di=2, observed_value=1, mispredict=0, outstanding 1->0.
- Push (idx 3, val 0), then resolve di=3, val 1 -> mispredict one cycle; squash=1 for 2 cycles; spec_ready=0 for those 2 cycles; outstanding=0; then RUN.
- Push 4 entries (DEPTH=4) -> spec_ready=0. Next cycle, push plus matching resolve together -> outstanding stays 4, and the head advances in order.
- FIFO empty, resolve di=1, val 1 -> training write only; no mispredict, no pop.
- Head idx 0 pending, resolve di=5 -> training only; head is still outstanding. A following resolve di=0 then retires it.
- Assert reset during FLUSH cycle 1 -> squash, mispredict, and outstanding are 0 immediately; with STATS_EN, both counters read 0.

Source files
------------

// File: rtl/predicate_speculation_resolver.sv
// Purpose: in-order checker for speculative predicate predictions; trains the predictor bank and squashes on mismatch.
// Latency: training outputs, mispredict and squash are registered (1 cycle after the resolving write).
// Backpressure: spec_ready drops when the FIFO is full or during FLUSH; resolves are never stalled. Stats: PREDICATE_SPECULATION_STATS_EN.
`ifndef TIA_NUM_PREDICATES
`define TIA_NUM_PREDICATES 8
`endif
`ifndef TIA_DI_WIDTH
`define TIA_DI_WIDTH 4
`endif

module predicate_speculation_resolver #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   spec_valid,
    output logic                                   spec_ready,
    input  logic [$clog2(`TIA_NUM_PREDICATES)-1:0] spec_index,
    input  logic                                   spec_value,
    input  logic                                   resolve_valid,
    input  logic [`TIA_DI_WIDTH-1:0]               resolve_di,
    input  logic                                   resolve_value,
    output logic                                   datapath_write,
    output logic [`TIA_DI_WIDTH-1:0]               datapath_di,
    output logic                                   observed_value,
    output logic                                   mispredict,
    output logic                                   squash,
    output logic [$clog2(DEPTH+1)-1:0]             outstanding,
    output logic [15:0]                            resolved_count,
    output logic [15:0]                            mispredict_count
);
    localparam int IW = $clog2(`TIA_NUM_PREDICATES);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam int CW = $clog2(FLUSH_CYCLES+1);
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state;
    logic [CW-1:0]   flush_cnt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [OW-1:0]   occ;
    logic [IW-1:0]   idx_q [DEPTH];
    logic            val_q [DEPTH];

    logic run_en, head_hit, miss, push;

    always_comb begin
        run_en   = enable && (state == RUN);
        head_hit = run_en && resolve_valid && (occ != '0) &&
                   (idx_q[rd_ptr] == resolve_di[IW-1:0]);
        miss     = head_hit && (val_q[rd_ptr] != resolve_value);
        // A full FIFO may still take a push when the head retires in the same cycle.
        push     = run_en && spec_valid && ((occ != DEPTH_C) || head_hit) && !miss;
    end

    assign spec_ready  = run_en && (occ != DEPTH_C);
    assign outstanding = occ;

    always_ff @(posedge clock) begin
        if (push) begin
            idx_q[wr_ptr] <= spec_index;
            val_q[wr_ptr] <= spec_value;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= RUN;
            flush_cnt      <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            datapath_write <= 1'b0;
            datapath_di    <= '0;
            observed_value <= 1'b0;
            mispredict     <= 1'b0;
            squash         <= 1'b0;
        end else if (enable) begin
            datapath_write <= resolve_valid;
            if (resolve_valid) begin
                datapath_di    <= resolve_di;
                observed_value <= resolve_value;
            end
            mispredict <= miss;
            case (state)
                RUN: begin
                    if (miss) begin
                        state     <= FLUSH;
                        squash    <= 1'b1;
                        flush_cnt <= CW'(FLUSH_CYCLES-1);
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        occ       <= '0;
                    end else begin
                        if (push)
                            wr_ptr <= wr_ptr + PW'(1);
                        if (head_hit)
                            rd_ptr <= rd_ptr + PW'(1);
                        if (push && !head_hit)
                            occ <= occ + OW'(1);
                        else if (!push && head_hit)
                            occ <= occ - OW'(1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state  <= RUN;
                        squash <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - CW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end else begin
            datapath_write <= 1'b0;
            mispredict     <= 1'b0;
        end
    end

`ifdef PREDICATE_SPECULATION_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resolved_count   <= '0;
            mispredict_count <= '0;
        end else begin
            if (head_hit && resolved_count != 16'hFFFF)
                resolved_count <= resolved_count + 16'd1;
            if (miss && mispredict_count != 16'hFFFF)
                mispredict_count <= mispredict_count + 16'd1;
        end
    end
`else
    assign resolved_count   = '0;
    assign mispredict_count = '0;
`endif
endmodule
